// File: rtl/riscv_defines_apu.sv
// Package riscv_defines_apu
//   Multiplier operator encodings shared by the APU cluster, and the stage
//   payload used by the dsp_mult_pipe result pipeline.
package riscv_defines_apu;

  localparam int unsigned MUL_OP_WIDTH = 3;

  localparam logic [MUL_OP_WIDTH-1:0] MUL_MAC32 = 3'b000;
  localparam logic [MUL_OP_WIDTH-1:0] MUL_MSU32 = 3'b001;
  localparam logic [MUL_OP_WIDTH-1:0] MUL_I     = 3'b010;
  localparam logic [MUL_OP_WIDTH-1:0] MUL_IR    = 3'b011;
  localparam logic [MUL_OP_WIDTH-1:0] MUL_DOT8  = 3'b100;
  localparam logic [MUL_OP_WIDTH-1:0] MUL_DOT16 = 3'b101;
  localparam logic [MUL_OP_WIDTH-1:0] MUL_H     = 3'b110;

  // Widest tag any pipe instance may carry; instances slice to TAG_WIDTH.
  localparam int unsigned DSP_MULT_TAG_MAX = 8;

  typedef struct packed {
    logic                        valid;
    logic [31:0]                 result;
    logic [DSP_MULT_TAG_MAX-1:0] tag;
  } dsp_mult_stage_t;

endpackage

// File: rtl/dsp_mult.sv
// dsp_mult
//   Combinational dot-product multiplier.
//   DOT8 : sum of four byte products + op_c_i (mod 2^32)
//   DOT16: sum of two halfword products + op_c_i (mod 2^32)
//   Any other operator returns 0.
// Ports:
//   operator_i   multiplier operator (MUL_* encoding)
//   op_a_i/op_b_i/op_c_i  operands, op_c_i is the accumulator
//   dot_signed_i [1]: A signed, [0]: B signed
//   result_o     32-bit result
module dsp_mult
  import riscv_defines_apu::*;
(
  input  logic [2:0]  operator_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [31:0] op_c_i,
  input  logic [1:0]  dot_signed_i,
  output logic [31:0] result_o
);

  // Each lane is widened by one bit so signed and unsigned share one multiplier.
  function automatic logic [31:0] dot8(input logic [31:0] a, input logic [31:0] b,
                                       input logic [1:0] sgn);
    logic [31:0]       acc;
    logic signed [8:0]  ea;
    logic signed [8:0]  eb;
    logic signed [17:0] p;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      ea  = {sgn[1] & a[8*i+7], a[8*i +: 8]};
      eb  = {sgn[0] & b[8*i+7], b[8*i +: 8]};
      p   = ea * eb;
      acc = acc + {{14{p[17]}}, p};
    end
    return acc;
  endfunction

  function automatic logic [31:0] dot16(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] sgn);
    logic [31:0]        acc;
    logic signed [16:0] ea;
    logic signed [16:0] eb;
    logic signed [33:0] p;
    acc = '0;
    for (int i = 0; i < 2; i++) begin
      ea  = {sgn[1] & a[16*i+15], a[16*i +: 16]};
      eb  = {sgn[0] & b[16*i+15], b[16*i +: 16]};
      p   = ea * eb;
      acc = acc + 32'(p);
    end
    return acc;
  endfunction

  always_comb begin
    result_o = '0;
    unique case (operator_i)
      MUL_DOT8:  result_o = dot8(op_a_i, op_b_i, dot_signed_i) + op_c_i;
      MUL_DOT16: result_o = dot16(op_a_i, op_b_i, dot_signed_i) + op_c_i;
      default:   result_o = '0;
    endcase
  end

endmodule

// File: rtl/dsp_mult_pipe.sv
// dsp_mult_pipe
//   Handshaked, PIPE_REGS-deep result pipeline in front of dsp_mult.
//   Requests use req/gnt, results leave on valid/ready with full backpressure;
//   a stall freezes every stage (no bubble collapse).
// Ports:
//   clk_i, rst_i (async, active-high)
//   req_i/gnt_o, operator_i, op_a_i, op_b_i, op_c_i, dot_signed_i, tag_i : request side
//   valid_o/ready_i, result_o, tag_o : result side
//   busy_o : some stage holds a valid entry
//   perf_ops_o, perf_stall_o : accept / stall counters
// Build option:
//   DSP_MULT_PIPE_PERF_EN  builds the perf counters; otherwise they read 0.
module dsp_mult_pipe
  import riscv_defines_apu::*;
#(
  parameter int unsigned PIPE_REGS = 2,
  parameter int unsigned TAG_WIDTH = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [2:0]           operator_i,
  input  logic [31:0]          op_a_i,
  input  logic [31:0]          op_b_i,
  input  logic [31:0]          op_c_i,
  input  logic [1:0]           dot_signed_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [31:0]          result_o,
  output logic [TAG_WIDTH-1:0] tag_o,
  output logic                 busy_o,
  output logic [31:0]          perf_ops_o,
  output logic [31:0]          perf_stall_o
);

  localparam int unsigned LAST = PIPE_REGS - 1;

  dsp_mult_stage_t stage_q [PIPE_REGS];
  dsp_mult_stage_t stage_d [PIPE_REGS];
  logic [31:0]     mult_result;
  logic            stall;
  logic            accept;
  logic            busy;
  logic            unused_tag_hi;

  dsp_mult u_dsp_mult (
    .operator_i   (operator_i),
    .op_a_i       (op_a_i),
    .op_b_i       (op_b_i),
    .op_c_i       (op_c_i),
    .dot_signed_i (dot_signed_i),
    .result_o     (mult_result)
  );

  // Grant drops combinationally with ready_i when the head result is blocked.
  assign stall  = stage_q[LAST].valid & ~ready_i;
  assign gnt_o  = ~rst_i & ~stall;
  assign accept = req_i & gnt_o;

  // Shift every stage on a non-stall cycle; stage 0 loads the accept bit.
  always_comb begin
    stage_d = stage_q;
    if (!stall) begin
      stage_d[0].valid  = accept;
      stage_d[0].result = mult_result;
      stage_d[0].tag    = DSP_MULT_TAG_MAX'(tag_i);
      for (int unsigned k = 1; k < PIPE_REGS; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < PIPE_REGS; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int unsigned k = 0; k < PIPE_REGS; k++) begin
      busy = busy | stage_q[k].valid;
    end
  end

  assign valid_o       = stage_q[LAST].valid;
  assign result_o      = stage_q[LAST].result;
  assign tag_o         = stage_q[LAST].tag[TAG_WIDTH-1:0];
  assign busy_o        = busy;
  assign unused_tag_hi = ^stage_q[LAST].tag;

`ifdef DSP_MULT_PIPE_PERF_EN
  logic [31:0] perf_ops_q;
  logic [31:0] perf_stall_q;

  // Accept and stall are mutually exclusive, both counters wrap naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (accept) perf_ops_q   <= perf_ops_q + 32'd1;
      if (stall)  perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_ops_o   = perf_ops_q;
  assign perf_stall_o = perf_stall_q;
`else
  assign perf_ops_o   = '0;
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_dsp_mult_pipe.sv
// tb_dsp_mult_pipe
//   Directed bench for dsp_mult_pipe (PIPE_REGS=2, TAG_WIDTH=5) with an
//   in-bench transaction model: arithmetic from the operator definitions,
//   a queue of in-flight results, and counts of accepts and stall cycles.
module tb_dsp_mult_pipe;

  localparam int PIPE = 2;
  localparam int TW   = 5;

  localparam logic [2:0] OP_MAC32 = 3'b000;
  localparam logic [2:0] OP_DOT8  = 3'b100;
  localparam logic [2:0] OP_DOT16 = 3'b101;

  logic          clk;
  logic          rst_i;
  logic          req_i;
  logic          gnt_o;
  logic [2:0]    operator_i;
  logic [31:0]   op_a_i;
  logic [31:0]   op_b_i;
  logic [31:0]   op_c_i;
  logic [1:0]    dot_signed_i;
  logic [TW-1:0] tag_i;
  logic          valid_o;
  logic          ready_i;
  logic [31:0]   result_o;
  logic [TW-1:0] tag_o;
  logic          busy_o;
  logic [31:0]   perf_ops_o;
  logic [31:0]   perf_stall_o;

  dsp_mult_pipe #(.PIPE_REGS(PIPE), .TAG_WIDTH(TW)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .operator_i   (operator_i),
    .op_a_i       (op_a_i),
    .op_b_i       (op_b_i),
    .op_c_i       (op_c_i),
    .dot_signed_i (dot_signed_i),
    .tag_i        (tag_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .result_o     (result_o),
    .tag_o        (tag_o),
    .busy_o       (busy_o),
    .perf_ops_o   (perf_ops_o),
    .perf_stall_o (perf_stall_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference arithmetic: plain signed/unsigned integer lanes summed in 64 bits.
  function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] c,
                                               input logic [1:0] ds);
    longint s;
    longint x;
    longint y;
    s = 0;
    if (op == OP_DOT8) begin
      for (int i = 0; i < 4; i++) begin
        x = ds[1] ? longint'($signed(a[8*i +: 8])) : longint'(a[8*i +: 8]);
        y = ds[0] ? longint'($signed(b[8*i +: 8])) : longint'(b[8*i +: 8]);
        s = s + x * y;
      end
      return 32'(s + longint'(c));
    end else if (op == OP_DOT16) begin
      for (int i = 0; i < 2; i++) begin
        x = ds[1] ? longint'($signed(a[16*i +: 16])) : longint'(a[16*i +: 16]);
        y = ds[0] ? longint'($signed(b[16*i +: 16])) : longint'(b[16*i +: 16]);
        s = s + x * y;
      end
      return 32'(s + longint'(c));
    end
    return 32'd0;
  endfunction

  typedef struct {
    logic [31:0]   res;
    logic [TW-1:0] tag;
    int            cyc;
  } exp_t;

  exp_t        model_q[$];
  int          cyc        = 0;
  logic [31:0] m_ops      = 0;
  logic [31:0] m_stalls   = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_res   = 0;
  logic [TW-1:0] prev_tag = '0;

  // Per-cycle compare against the transaction model, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t f;
    cyc++;
    if (rst_i) begin
      chk("rst_valid",  32'(valid_o), 32'd0);
      chk("rst_busy",   32'(busy_o), 32'd0);
      chk("rst_result", result_o, 32'd0);
      chk("rst_tag",    32'(tag_o), 32'd0);
      chk("rst_perf_ops",   perf_ops_o, 32'd0);
      chk("rst_perf_stall", perf_stall_o, 32'd0);
      model_q.delete();
      m_ops      = 0;
      m_stalls   = 0;
      prev_stall = 1'b0;
    end else begin
      chk("gnt_rule", 32'(gnt_o), 32'(!(valid_o && !ready_i)));
      chk("busy_vs_inflight", 32'(busy_o), 32'(model_q.size() != 0));
      if (valid_o) begin
        if (model_q.size() == 0) begin
          chk("spurious_valid", 32'(valid_o), 32'd0);
        end else begin
          f = model_q[0];
          chk("order_result", result_o, f.res);
          chk("order_tag", 32'(tag_o), 32'(f.tag));
          chk("latency_min", 32'((cyc - f.cyc) >= PIPE), 32'd1);
        end
      end
      if (prev_stall) begin
        chk("hold_valid",  32'(valid_o), 32'd1);
        chk("hold_result", result_o, prev_res);
        chk("hold_tag",    32'(tag_o), 32'(prev_tag));
      end
`ifdef DSP_MULT_PIPE_PERF_EN
      chk("perf_ops",   perf_ops_o, m_ops);
      chk("perf_stall", perf_stall_o, m_stalls);
`else
      chk("perf_ops_tied",   perf_ops_o, 32'd0);
      chk("perf_stall_tied", perf_stall_o, 32'd0);
`endif
      if (valid_o && ready_i && model_q.size() != 0) void'(model_q.pop_front());
      if (req_i && gnt_o) begin
        f.res = model_result(operator_i, op_a_i, op_b_i, op_c_i, dot_signed_i);
        f.tag = tag_i;
        f.cyc = cyc;
        model_q.push_back(f);
        m_ops = m_ops + 32'd1;
      end
      if (valid_o && !ready_i) m_stalls = m_stalls + 32'd1;
      prev_stall = valid_o && !ready_i;
      prev_res   = result_o;
      prev_tag   = tag_o;
    end
  end

  task automatic issue(input logic r, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c, input logic [1:0] ds,
                       input logic [TW-1:0] t);
    @(posedge clk);
    #1;
    req_i        = r;
    operator_i   = op;
    op_a_i       = a;
    op_b_i       = b;
    op_c_i       = c;
    dot_signed_i = ds;
    tag_i        = t;
  endtask

  task automatic idle();
    issue(1'b0, 3'b111, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678, 2'b11, '1);
  endtask

  // Single request; checks exact latency and the literal result/tag.
  task automatic single(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c, input logic [1:0] ds,
                        input logic [TW-1:0] t, input logic [31:0] exp_res);
    issue(1'b1, op, a, b, c, ds, t);
    @(negedge clk);
    chk({nm, "_gnt"}, 32'(gnt_o), 32'd1);
    idle();
    @(negedge clk);
    chk({nm, "_early"}, 32'(valid_o), 32'd0);
    idle();
    @(negedge clk);
    chk({nm, "_valid"}, 32'(valid_o), 32'd1);
    chk({nm, "_result"}, result_o, exp_res);
    chk({nm, "_tag"}, 32'(tag_o), 32'(t));
    idle();
    @(negedge clk);
    chk({nm, "_drained"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; req_i = 1'b0; ready_i = 1'b1;
    operator_i = '0; op_a_i = '0; op_b_i = '0; op_c_i = '0; dot_signed_i = '0; tag_i = '0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("post_rst_gnt", 32'(gnt_o), 32'd1);

    single("dot8_basic",  OP_DOT8,  32'h01020304, 32'h01010101, 32'd0, 2'b00, 5'd3, 32'h0000000A);
    single("dot8_signed", OP_DOT8,  32'hFFFFFFFF, 32'h02020202, 32'd0, 2'b11, 5'd4, 32'hFFFFFFF8);
    single("dot16_acc",   OP_DOT16, 32'h00020003, 32'h00040005, 32'd1, 2'b00, 5'd5, 32'd24);
    single("dot16_signed", OP_DOT16, 32'hFFFF0002, 32'h00030004, 32'd0, 2'b11, 5'd6, 32'd5);
    single("mac32_zero",  OP_MAC32, 32'd5, 32'd6, 32'd7, 2'b00, 5'd7, 32'd0);

    // Back-to-back: four accepts, four consecutive results in order.
    for (int i = 0; i < 8; i++) begin
      if (i < 4) issue(1'b1, OP_DOT16, 32'h00010001 * 32'(i + 1), 32'h00010001, 32'(i), 2'b00, TW'(i));
      else idle();
      @(negedge clk);
      chk("b2b_gnt", 32'(gnt_o), 32'd1);
      if (i >= 2 && i < 6) begin
        chk("b2b_valid", 32'(valid_o), 32'd1);
        chk("b2b_tag", 32'(tag_o), 32'(i - 2));
      end else begin
        chk("b2b_bubble", 32'(valid_o), 32'd0);
      end
    end

    // Backpressure: fill the pipe with ready low, hold five stall cycles.
    issue(1'b1, OP_DOT16, 32'h00010001, 32'h00020002, 32'd0, 2'b00, 5'd10);
    ready_i = 1'b0;
    @(negedge clk);
    chk("bp_fill0_gnt", 32'(gnt_o), 32'd1);
    issue(1'b1, OP_DOT16, 32'h00030003, 32'h00010001, 32'd10, 2'b00, 5'd11);
    @(negedge clk);
    chk("bp_fill1_gnt", 32'(gnt_o), 32'd1);
    for (int s = 0; s < 5; s++) begin
      issue(1'b1, OP_DOT16, 32'h00100010, 32'h00010001, 32'd0, 2'b00, 5'd12);
      @(negedge clk);
      chk("bp_stall_gnt", 32'(gnt_o), 32'd0);
      chk("bp_stall_valid", 32'(valid_o), 32'd1);
      chk("bp_stall_tag", 32'(tag_o), 32'd10);
      chk("bp_stall_result", result_o, 32'd4);
      chk("bp_busy", 32'(busy_o), 32'd1);
    end
    issue(1'b1, OP_DOT16, 32'h00100010, 32'h00010001, 32'd0, 2'b00, 5'd12);
    ready_i = 1'b1;
    @(negedge clk);
`ifdef DSP_MULT_PIPE_PERF_EN
    chk("bp_perf_stall", perf_stall_o, 32'd5);
`endif
    chk("bp_release_gnt", 32'(gnt_o), 32'd1);
    chk("bp_release_tag", 32'(tag_o), 32'd10);
    idle();
    @(negedge clk);
    chk("bp_next_tag", 32'(tag_o), 32'd11);
    chk("bp_next_result", result_o, 32'd16);
    idle();
    @(negedge clk);
    chk("bp_last_tag", 32'(tag_o), 32'd12);
    chk("bp_last_result", result_o, 32'd32);
    idle();
    @(negedge clk);
    chk("bp_empty", 32'(valid_o), 32'd0);
    chk("bp_not_busy", 32'(busy_o), 32'd0);

    // Reset with two entries in flight.
    issue(1'b1, OP_DOT8, 32'h01010101, 32'h01010101, 32'd0, 2'b00, 5'd20);
    issue(1'b1, OP_DOT8, 32'h02020202, 32'h01010101, 32'd0, 2'b00, 5'd21);
    @(negedge clk);
    chk("mid_busy", 32'(busy_o), 32'd1);
    @(posedge clk);
    #1;
    req_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(valid_o), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale", 32'(valid_o), 32'd0);
    end

    single("post_rst_dot8", OP_DOT8, 32'h01020304, 32'h01010101, 32'd0, 2'b00, 5'd9, 32'h0000000A);

    @(negedge clk);
    chk("end_queue_empty", 32'(model_q.size()), 32'd0);
    chk("end_not_busy", 32'(busy_o), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dsp_mult_pipe.md
Name: dsp_mult_pipe

Overview:
Pipelined, handshaked front-end for the shared combinational dot-product multiplier (dsp_mult) in the APU cluster.
- Accepts requests from the APU interconnect with a req/gnt handshake.
- Drives dsp_mult with the request operands.
- Carries the result and request tag through PIPE_REGS register stages.
- Presents the result on a valid/ready output with full backpressure.

Parameters:
PIPE_REGS, 2, number of result register stages = latency in cycles; legal range 1..4.
TAG_WIDTH, 5, width of the request tag returned with each result.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
req_i  in  1  request valid
gnt_o  out  1  request granted; accept = req_i & gnt_o
operator_i  in  3  multiplier operator (MUL_* encoding from riscv_defines_apu)
op_a_i  in  32  operand A
op_b_i  in  32  operand B
op_c_i  in  32  accumulator operand C
dot_signed_i  in  2  [1]: A signed, [0]: B signed
tag_i  in  TAG_WIDTH  request tag
valid_o  out  1  result valid
ready_i  in  1  consumer ready; transfer = valid_o & ready_i
result_o  out  32  result
tag_o  out  TAG_WIDTH  tag of result
busy_o  out  1  any stage holds a valid entry
perf_ops_o  out  32  accepted-request counter (optional feature)
perf_stall_o  out  32  stall-cycle counter (optional feature)

Behaviour:
Reset and reset mid-operation:
- On reset, all stage valid bits clear and every in-flight result is dropped.
- Reset values: valid_o=0, busy_o=0, result_o=0, tag_o=0, perf counters=0.
- gnt_o=1 while rst_i is deasserted and no stall is present.

Datapath:
- dsp_mult is driven combinationally from operator_i/op_a_i/op_b_i/op_c_i/dot_signed_i.
- On accept, its 32-bit result and tag_i are captured into stage 1.
- Stage k shifts into stage k+1 each non-stall cycle.
- Stage PIPE_REGS drives valid_o/result_o/tag_o. All outputs are registered.

Arithmetic rules:
- MUL_DOT8 and MUL_DOT16 produce the dot-product result plus op_c_i, modulo 2^32.
- Any other operator produces 0. The result still returns with its tag and still occupies a slot.

Stall and handshake:
- stall = valid_o & ~ready_i. On a stall the whole pipeline holds; there is no bubble collapse.
- gnt_o = ~stall. This is a combinational path from ready_i.
- Without a stall, stage 1 loads the accept bit as its valid, so empty slots propagate as bubbles.
- Latency: an accept in cycle N gives valid_o in cycle N+PIPE_REGS, absent stalls.
- Throughput: 1 result/cycle.
- Ordering: results leave in strict acceptance order.
- Simultaneous accept and output transfer in the same cycle is legal and required for full throughput.
- Once valid_o is asserted, result_o and tag_o stay stable until the transfer completes.
- While not granted, input operands are ignored and no state changes except the stall counter.

busy_o:
- busy_o = OR of all stage valid bits.

Optional Feature:
Macro DSP_MULT_PIPE_PERF_EN.
- Defined: perf_ops_o increments on each accept. perf_stall_o increments on each cycle with stall=1. Both wrap at 2^32 and clear on reset.
- Undefined: counter registers are not built and both ports are tied to 0.

Decomposition:
- Operator encodings (MUL_DOT8, MUL_DOT16, MUL_MAC32, MUL_MSU32) come from package riscv_defines_apu.
- Add to that package a packed struct dsp_mult_stage_t {valid, result[31:0], tag}. Tag width is set locally by the module parameter, so the struct uses a package constant DSP_MULT_TAG_MAX=8 and the module slices the tag to TAG_WIDTH.
- One sub-module instance: the existing dsp_mult.
- The stage array is an unpacked array of dsp_mult_stage_t; no further sub-modules.

Test Plan:
- Basic DOT8 (PIPE_REGS=2): MUL_DOT8, a=0x01020304, b=0x01010101, c=0, dot_signed=00, tag=3, ready_i=1 -> valid_o exactly 2 cycles after accept, result_o=0x0000000A, tag_o=3.
- Signed DOT8: a=0xFFFFFFFF, b=0x02020202, c=0, dot_signed=11 -> result_o=0xFFFFFFF8.
- DOT16 with accumulator: a=0x00020003, b=0x00040005, c=1, dot_signed=00 -> result_o=24.
- Back-to-back and ordering: 4 consecutive DOT16 requests with tags 0..3 and ready_i=1 -> gnt_o stays 1, valid_o high 4 consecutive cycles, tags 0,1,2,3 in order.
- Backpressure: with a full pipe, hold ready_i=0 for 5 cycles -> gnt_o=0 and result_o/tag_o stable for all 5 cycles, no loss or duplication; perf_stall_o=5 when the macro is defined.
- Reset and unsupported op: a MUL_MAC32 request returns result_o=0 with its tag. Assert rst_i with 2 entries in flight -> valid_o=0 and busy_o=0 immediately, no stale results afterwards.
